// File: rtl/rpn_alu_ctrl_pkg.sv
// Shared types for the RPN calculator controller: FSM states, ALU opcodes,
// and bit positions of the {N,Z,C,V,P} flag vector.
package rpn_alu_ctrl_pkg;

    localparam int unsigned FLAG_W = 5;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned CNT_W  = 8;

    // Flag bit indices within the 5-bit flag vector
    localparam int unsigned FLG_N = 4;
    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_P = 0;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        SHOW    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_ADD = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the RPN controller.
// Ports:
//   A, B    : M-bit operands
//   OpCode  : SUB (A-B), ADD, OR, AND
//   Result  : low M bits of the (M+1)-bit operation
//   Flags   : {N,Z,C,V,P}; C is carry for ADD, borrow for SUB
module alu_core
    import rpn_alu_ctrl_pkg::*;
#(
    parameter int unsigned M = 8
) (
    input  logic [M-1:0]      A,
    input  logic [M-1:0]      B,
    input  op_t               OpCode,
    output logic [M-1:0]      Result,
    output logic [FLAG_W-1:0] Flags
);

    logic [M:0] wide;
    logic       carry;
    logic       ovf;

    // Arithmetic runs one bit wider so bit M carries out (ADD) or borrows (SUB)
    always_comb begin
        wide  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (OpCode)
            OP_SUB: begin
                wide  = {1'b0, A} - {1'b0, B};
                carry = wide[M];
                ovf   = (A[M-1] != B[M-1]) && (wide[M-1] != A[M-1]);
            end
            OP_ADD: begin
                wide  = {1'b0, A} + {1'b0, B};
                carry = wide[M];
                ovf   = (A[M-1] == B[M-1]) && (wide[M-1] != A[M-1]);
            end
            OP_OR:   wide = {1'b0, A | B};
            OP_AND:  wide = {1'b0, A & B};
            default: wide = '0;
        endcase
    end

    // Result and status flags
    always_comb begin
        Result       = wide[M-1:0];
        Flags        = '0;
        Flags[FLG_N] = Result[M-1];
        Flags[FLG_Z] = (Result == '0);
        Flags[FLG_C] = carry;
        Flags[FLG_V] = ovf;
        Flags[FLG_P] = ^Result;
    end

endmodule

// File: rtl/rpn_alu_ctrl.sv
// RPN calculator controller: operands A and B, then an opcode, are entered
// with single presses of a debounced button; the ALU result is then held
// for display. Optional chaining reuses the result as the next A.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   data_in       : operand switches
//   op_in         : opcode switches (00 SUB, 01 ADD, 10 OR, 11 AND)
//   enter         : debounced push-button level
//   chain         : feed a confirmed result back as the next A
//   display       : value for the 7-segment driver
//   flags         : registered {N,Z,C,V,P}
//   state_onehot  : {SHOW,WAIT_OP,WAIT_B,WAIT_A}
//   result_valid  : high while a computed result is held
//   op_count      : completed operations, saturating at 8'hFF
module rpn_alu_ctrl
    import rpn_alu_ctrl_pkg::*;
#(
    parameter int unsigned M = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [M-1:0]      data_in,
    input  logic [OP_W-1:0]   op_in,
    input  logic              enter,
    input  logic              chain,
    output logic [M-1:0]      display,
    output logic [FLAG_W-1:0] flags,
    output logic [3:0]        state_onehot,
    output logic              result_valid,
    output logic [CNT_W-1:0]  op_count
);

    state_t              state;
    logic                enter_q;
    logic [M-1:0]        reg_a;
    logic [M-1:0]        reg_b;
    op_t                 reg_op;
    logic [M-1:0]        result_reg;
    op_t                 alu_op;
    logic [M-1:0]        alu_result;
    logic [FLAG_W-1:0]   alu_flags;
    logic                press;

    // A press is the rising edge of the button level only
    assign press = enter & ~enter_q;

    // ALU follows the live opcode while it is being chosen, else the latched one
    assign alu_op = (state == WAIT_OP) ? op_t'(op_in) : reg_op;

    alu_core #(.M(M)) u_alu (
        .A      (reg_a),
        .B      (reg_b),
        .OpCode (alu_op),
        .Result (alu_result),
        .Flags  (alu_flags)
    );

    // Controller FSM with its datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_A;
            enter_q      <= 1'b0;
            reg_a        <= '0;
            reg_b        <= '0;
            reg_op       <= OP_SUB;
            result_reg   <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
            op_count     <= '0;
        end else begin
            enter_q <= enter;
            if (press) begin
                case (state)
                    WAIT_A: begin
                        reg_a <= data_in;
                        state <= WAIT_B;
                    end
                    WAIT_B: begin
                        reg_b <= data_in;
                        state <= WAIT_OP;
                    end
                    WAIT_OP: begin
                        reg_op       <= op_t'(op_in);
                        result_reg   <= alu_result;
                        flags        <= alu_flags;
                        result_valid <= 1'b1;
                        if (op_count != {CNT_W{1'b1}}) begin
                            op_count <= op_count + CNT_W'(1);
                        end
                        state <= SHOW;
                    end
                    SHOW: begin
                        result_valid <= 1'b0;
                        if (chain) begin
                            reg_a <= result_reg;
                            state <= WAIT_B;
                        end else begin
                            state <= WAIT_A;
                        end
                    end
                    default: state <= WAIT_A;
                endcase
            end
        end
    end

    // Operand entry shows the live switches so the user sees what will be latched
    always_comb begin
        display = data_in;
        case (state)
            WAIT_A, WAIT_B: display = data_in;
            WAIT_OP:        display = reg_b;
            SHOW:           display = result_reg;
            default:        display = data_in;
        endcase
    end

    assign state_onehot = {state == SHOW, state == WAIT_OP,
                           state == WAIT_B, state == WAIT_A};

endmodule

// File: tb/tb_rpn_alu_ctrl.sv
// Self-checking bench for rpn_alu_ctrl (M=8) with a behavioural reference.
module tb_rpn_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [1:0] op_in;
    logic       enter;
    logic       chain;
    logic [7:0] display;
    logic [4:0] flags;
    logic [3:0] state_onehot;
    logic       result_valid;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    // Reference model: state index 0=WAIT_A 1=WAIT_B 2=WAIT_OP 3=SHOW
    int         m_state;
    logic [7:0] m_a, m_b, m_res;
    logic [4:0] m_flg;
    logic       m_valid;
    int         m_cnt;

    rpn_alu_ctrl #(.M(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .op_in        (op_in),
        .enter        (enter),
        .chain        (chain),
        .display      (display),
        .flags        (flags),
        .state_onehot (state_onehot),
        .result_valid (result_valid),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    function automatic int sval(input int u);
        return (u >= 128) ? u - 256 : u;
    endfunction

    task automatic ref_alu(input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op,
                           output logic [7:0] res, output logic [4:0] flg);
        int ua, ub, r, s;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (op)
            2'b00: begin
                r = (ua - ub + 256) % 256;
                c = (ua < ub);
                s = sval(ua) - sval(ub);
                v = (s < -128) || (s > 127);
            end
            2'b01: begin
                r = (ua + ub) % 256;
                c = (ua + ub) > 255;
                s = sval(ua) + sval(ub);
                v = (s < -128) || (s > 127);
            end
            2'b10:   r = int'(a | b);
            default: r = int'(a & b);
        endcase
        res = 8'(r);
        flg = {r >= 128, r == 0, c, v, ($countones(res) % 2) == 1};
    endtask

    task automatic model_reset();
        m_state = 0;
        m_a = 8'h00; m_b = 8'h00; m_res = 8'h00;
        m_flg = 5'b0; m_valid = 1'b0; m_cnt = 0;
    endtask

    task automatic model_press(input logic [7:0] d, input logic [1:0] op,
                               input logic ch);
        case (m_state)
            0: begin m_a = d; m_state = 1; end
            1: begin m_b = d; m_state = 2; end
            2: begin
                ref_alu(m_a, m_b, op, m_res, m_flg);
                m_valid = 1'b1;
                if (m_cnt < 255) m_cnt++;
                m_state = 3;
            end
            default: begin
                m_valid = 1'b0;
                if (ch) begin m_a = m_res; m_state = 1; end
                else    m_state = 0;
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] exp_disp;
        logic [3:0] exp_oh;
        exp_disp = (m_state <= 1) ? data_in : (m_state == 2) ? m_b : m_res;
        exp_oh   = 4'(1 << m_state);
        checks++;
        assert (display === exp_disp) else begin
            errors++;
            $error("FAIL %s display got %h exp %h", tag, display, exp_disp);
        end
        checks++;
        assert (flags === m_flg) else begin
            errors++;
            $error("FAIL %s flags got %b exp %b", tag, flags, m_flg);
        end
        checks++;
        assert (state_onehot === exp_oh) else begin
            errors++;
            $error("FAIL %s state_onehot got %b exp %b", tag, state_onehot, exp_oh);
        end
        checks++;
        assert (result_valid === m_valid) else begin
            errors++;
            $error("FAIL %s result_valid got %b exp %b", tag, result_valid, m_valid);
        end
        checks++;
        assert (op_count === 8'(m_cnt)) else begin
            errors++;
            $error("FAIL %s op_count got %h exp %h", tag, op_count, 8'(m_cnt));
        end
    endtask

    // One press: enter high across one rising edge, then low for one cycle
    task automatic press(input logic [7:0] d, input logic [1:0] op,
                         input logic ch, input string tag);
        data_in = d; op_in = op; chain = ch; enter = 1'b1;
        @(negedge clk);
        model_press(d, op, ch);
        enter = 1'b0;
        check_outputs(tag);
        @(negedge clk);
        check_outputs({tag, "_idle"});
    endtask

    task automatic do_reset();
        reset = 1'b1; enter = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_outputs("reset");
    endtask

    initial begin
        reset = 1'b1; data_in = 8'h00; op_in = 2'b00; enter = 1'b0; chain = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 7F + 01: signed overflow into 80
        press(8'h7F, 2'b00, 1'b0, "add_a");
        press(8'h01, 2'b00, 1'b0, "add_b");
        press(8'h00, 2'b01, 1'b0, "add_op");
        checks++;
        assert (display === 8'h80 && flags === 5'b10011) else begin
            errors++;
            $error("FAIL add_const got %h/%b exp 80/10011", display, flags);
        end
        press(8'h00, 2'b00, 1'b0, "show_ret");

        // 05-05 zero, then 03-05 borrow
        press(8'h05, 2'b00, 1'b0, "sub0_a");
        press(8'h05, 2'b00, 1'b0, "sub0_b");
        press(8'h00, 2'b00, 1'b0, "sub0_op");
        checks++;
        assert (display === 8'h00 && flags === 5'b01000) else begin
            errors++;
            $error("FAIL sub0_const got %h/%b exp 00/01000", display, flags);
        end
        press(8'h00, 2'b00, 1'b0, "show_ret2");
        press(8'h03, 2'b00, 1'b0, "subb_a");
        press(8'h05, 2'b00, 1'b0, "subb_b");
        press(8'h00, 2'b00, 1'b0, "subb_op");
        checks++;
        assert (display === 8'hFE && flags === 5'b10101) else begin
            errors++;
            $error("FAIL subb_const got %h/%b exp FE/10101", display, flags);
        end
        press(8'h00, 2'b00, 1'b0, "show_ret3");

        // F0 | 0F, then chain into AND with 01
        press(8'hF0, 2'b00, 1'b0, "or_a");
        press(8'h0F, 2'b00, 1'b0, "or_b");
        press(8'h00, 2'b10, 1'b0, "or_op");
        press(8'h00, 2'b00, 1'b1, "chain");
        press(8'h01, 2'b00, 1'b0, "and_b");
        press(8'h00, 2'b11, 1'b0, "and_op");
        checks++;
        assert (display === 8'h01 && flags === 5'b00001) else begin
            errors++;
            $error("FAIL and_const got %h/%b exp 01/00001", display, flags);
        end
        press(8'h00, 2'b00, 1'b0, "show_ret4");

        // Held button advances exactly one state; A latched at the edge
        data_in = 8'h3C; enter = 1'b1;
        @(negedge clk);
        model_press(8'h3C, 2'b00, 1'b0);
        data_in = 8'h55;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check_outputs("hold");
        end
        enter = 1'b0;
        @(negedge clk);
        press(8'h00, 2'b00, 1'b0, "hold_b");
        press(8'h00, 2'b01, 1'b0, "hold_op");
        checks++;
        assert (display === 8'h3C) else begin
            errors++;
            $error("FAIL hold_a got %h exp 3c", display);
        end
        press(8'h00, 2'b00, 1'b0, "show_ret5");

        // Reset in WAIT_OP with a simultaneous press
        press(8'h11, 2'b00, 1'b0, "rst_a");
        press(8'h22, 2'b00, 1'b0, "rst_b");
        data_in = 8'h33; op_in = 2'b01; enter = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; enter = 1'b0;
        model_reset();
        check_outputs("rst_press");
        @(negedge clk);
        check_outputs("rst_after");

        // Random operations; enough to saturate the counter
        for (int n = 0; n < 260; n++) begin
            if (m_state == 0) press(8'($urandom), 2'b00, 1'b0, "rnd_a");
            press(8'($urandom), 2'b00, 1'b0, "rnd_b");
            press(8'($urandom), 2'($urandom), 1'b0, "rnd_op");
            press(8'($urandom), 2'b00, 1'($urandom), "rnd_show");
        end
        checks++;
        assert (op_count === 8'hFF) else begin
            errors++;
            $error("FAIL sat got %h exp ff", op_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpn_alu_ctrl.md
RPN_ALU_CTRL -- requirements
Module: rpn_alu_ctrl

Interface
REQ-001 Parameter M, default 8: operand, result and display width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_in  input  M  operand value from switches.
REQ-005 op_in  input  2  opcode selection: 00 SUB (A-B), 01 ADD, 10 OR, 11 AND.
REQ-006 enter  input  1  debounced level from push-button; held any number of cycles.
REQ-007 chain  input  1  when 1, a confirmed result becomes the next A.
REQ-008 display  output  M  value to be shown on 7-segment driver.
REQ-009 flags  output  5  registered ALU flags {N,Z,C,V,P} at bits [4:0].
REQ-010 state_onehot  output  4  {SHOW,WAIT_OP,WAIT_B,WAIT_A} at bits [3:0].
REQ-011 result_valid  output  1  high while a computed result is held.
REQ-012 op_count  output  8  number of completed operations, saturating.

Function
REQ-013 enter SHALL be rising-edge detected internally (enter_q register); only an edge (enter=1, enter_q=0) counts as a press.
REQ-014 FSM states WAIT_A, WAIT_B, WAIT_OP, SHOW; transitions occur only on a press.
REQ-015 WAIT_A + press: reg_A <= data_in, go WAIT_B.
REQ-016 WAIT_B + press: reg_B <= data_in, go WAIT_OP.
REQ-017 WAIT_OP + press: reg_op <= op_in, go SHOW; the combinational ALU result of (reg_A, reg_B, op_in) and its flags SHALL be captured into result_reg/flags in the same edge; result_valid=1 and display=result one cycle after the press edge.
REQ-018 SHOW + press, chain=0: go WAIT_A, result_valid <= 0; result_reg and flags retained.
REQ-019 SHOW + press, chain=1: reg_A <= result_reg, go WAIT_B, result_valid <= 0.
REQ-020 display: data_in (live) in WAIT_A and WAIT_B; reg_B in WAIT_OP; result_reg in SHOW.
REQ-021 ALU arithmetic SHALL be M+1 bits wide; result = low M bits; C = bit M (carry for ADD, borrow for SUB).
REQ-022 V: ADD, A and B signs equal and result sign differs; SUB, A and B signs differ and result sign differs from A; V=C=0 for OR/AND.
REQ-023 N = result[M-1]; Z = (result==0); P = XOR-reduction of result (1 for an odd count of ones).
REQ-024 op_count SHALL increment on each WAIT_OP->SHOW transition and hold at 8'hFF.
REQ-025 A press held across many cycles SHALL advance exactly one state; a re-press requires enter low for at least one cycle.

Reset
REQ-026 reset=1 at a clock edge: state WAIT_A; reg_A, reg_B, reg_op, result_reg, flags, op_count, enter_q all 0; result_valid=0; it overrides a simultaneous press.
REQ-027 Reset mid-sequence (any state) SHALL discard partial operands; no flag or count change results from an interrupted sequence.

Structure
REQ-028 Shared package SHALL hold the state enum (WAIT_A, WAIT_B, WAIT_OP, SHOW), the opcode enum (OP_SUB=00, OP_ADD=01, OP_OR=10, OP_AND=11) and flag bit-index constants (FLG_N=4, FLG_Z=3, FLG_C=2, FLG_V=1, FLG_P=0).
REQ-029 One sub-module, alu_core #(M): purely combinational; inputs A, B, OpCode; outputs Result[M-1:0], Flags[4:0] per REQ-021..023. All registers reside in rpn_alu_ctrl.

Verification (M=8)
REQ-030 Press 7F, 01, op 01 -> display 80, flags 10011, result_valid=1 one cycle after the third press edge, op_count=1.
REQ-031 Press 05, 05, op 00 -> display 00, flags 01000; then 03, 05, op 00 -> display FE, flags 10101.
REQ-032 Press F0, 0F, op 10 -> FF, flags 10000; chain=1, press in SHOW, then 01 and op 11 -> display 01, flags 00001, state WAIT_OP->SHOW.
REQ-033 enter held high 20 cycles in WAIT_A -> exactly one transition to WAIT_B; reg_A = data_in at the edge.
REQ-034 reset asserted in WAIT_OP with a simultaneous press -> next cycle state_onehot=0001, flags=00000, op_count=0, result_valid=0.
REQ-035 Complete 260 operations -> op_count saturates at FF.
